// File: rtl/climate_ctrl.sv
// Hysteresis climate controller: IDLE/COOL/HEAT/LOCK/OFF with dwell and lockout.
// Define FAN_OVERRUN_EN to keep the fan running into the first FAN_RUN cycles of LOCK.
module climate_ctrl #(
    parameter int W       = 8,
    parameter int MIN_ON  = 16,
    parameter int LOCKOUT = 32,
    parameter int FAN_RUN = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic [W-1:0] sensor,
    input  logic [W-1:0] heat_on_th,
    input  logic [W-1:0] heat_off_th,
    input  logic [W-1:0] cool_off_th,
    input  logic [W-1:0] cool_on_th,
    output logic         cool_o,
    output logic         heat_o,
    output logic         fan_o,
    output logic [2:0]   state_o,
    output logic         cfg_err_o
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        COOL = 3'b001,
        HEAT = 3'b010,
        LOCK = 3'b011,
        OFF  = 3'b100
    } state_t;

    localparam int MX0  = (MIN_ON > LOCKOUT) ? MIN_ON : LOCKOUT;
    localparam int DMAX = ((MX0 > FAN_RUN) ? MX0 : FAN_RUN) - 1;
    localparam int DW   = (DMAX < 1) ? 1 : $clog2(DMAX + 1);

    localparam logic [DW-1:0] DSAT      = DW'(DMAX);
    localparam logic [DW-1:0] MIN_LAST  = DW'(MIN_ON - 1);
    localparam logic [DW-1:0] LOCK_LAST = DW'(LOCKOUT - 1);

    state_t        state, state_n;
    logic [DW-1:0] dwell, dwell_n;
    logic          fan_n;

    assign cfg_err_o = !((heat_on_th < heat_off_th) &&
                         (heat_off_th <= cool_off_th) &&
                         (cool_off_th < cool_on_th));

    assign state_o = state;

    always_comb begin
        state_n = state;
        unique case (state)
            OFF: begin
                if (en) state_n = IDLE;
            end
            IDLE: begin
                if (!cfg_err_o && sensor > cool_on_th)
                    state_n = COOL;
                else if (!cfg_err_o && sensor < heat_on_th)
                    state_n = HEAT;
            end
            COOL: begin
                if (cfg_err_o ||
                    (sensor < cool_off_th && dwell >= MIN_LAST))
                    state_n = LOCK;
            end
            HEAT: begin
                if (cfg_err_o ||
                    (sensor > heat_off_th && dwell >= MIN_LAST))
                    state_n = LOCK;
            end
            LOCK: begin
                if (dwell >= LOCK_LAST) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (!en) state_n = OFF;
    end

    // Dwell restarts on every state change so each state times itself.
    always_comb begin
        dwell_n = dwell;
        if (state_n != state)
            dwell_n = '0;
        else if (dwell < DSAT)
            dwell_n = dwell + 1'b1;
    end

    always_comb begin
        fan_n = (state_n == COOL) || (state_n == HEAT);
`ifdef FAN_OVERRUN_EN
        if (state_n == LOCK && dwell_n < DW'(FAN_RUN))
            fan_n = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            dwell  <= '0;
            cool_o <= 1'b0;
            heat_o <= 1'b0;
            fan_o  <= 1'b0;
        end else begin
            state  <= state_n;
            dwell  <= dwell_n;
            cool_o <= (state_n == COOL);
            heat_o <= (state_n == HEAT);
            fan_o  <= fan_n;
        end
    end

endmodule
